// File: rtl/period_meter_pkg.sv
// Shared definitions for period_meter: FSM state encoding and averaging constants.
package period_meter_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARM     = 2'd1;
   localparam logic [1:0] ST_MEASURE = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ARM     = ST_ARM,
      MEASURE = ST_MEASURE
   } state_e;

   localparam int unsigned AVG_DEPTH = 4;
   localparam int unsigned AVG_SHIFT = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Multi-flop synchroniser for the asynchronous input plus a rising-edge detector
// on the synchronised level.
module edge_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_d    <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_d;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of sig_in in clk cycles, with a valid/ready result
// register. Optional 4-period averaging is enabled by defining PERIOD_METER_AVG_EN.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = 28,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun,
   output logic             timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             s;
   logic             rise;
   state_e           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] hcnt;
   logic             at_max;
   logic             meas_rise;
   logic             timeout_evt;
   logic             pub_fire;
   logic [CNT_W-1:0] pub_period;
   logic [CNT_W-1:0] pub_high;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_edge_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .s      (s),
      .rise   (rise)
   );

   assign at_max      = (cnt == CNT_MAX);
   assign meas_rise   = en && (state == MEASURE) && rise;
   // An edge coinciding with the terminal count still wins over the timeout.
   assign timeout_evt = en && ((state == ARM) || (state == MEASURE)) && !rise && at_max;

`ifdef PERIOD_METER_AVG_EN
   logic [CNT_W+1:0] acc_p;
   logic [CNT_W+1:0] acc_h;
   logic [CNT_W+1:0] sum_p;
   logic [CNT_W+1:0] sum_h;
   logic [1:0]       avg_idx;
   logic             avg_last;

   always_comb begin
      sum_p      = acc_p + {2'b00, cnt};
      sum_h      = acc_h + {2'b00, hcnt};
      avg_last   = (avg_idx == 2'(AVG_DEPTH - 1));
      pub_fire   = meas_rise && avg_last;
      pub_period = sum_p[AVG_SHIFT +: CNT_W];
      pub_high   = sum_h[AVG_SHIFT +: CNT_W];
   end

   always_ff @(posedge clk) begin
      if (rst || !en || timeout_evt || (state != MEASURE)) begin
         acc_p   <= '0;
         acc_h   <= '0;
         avg_idx <= '0;
      end else if (meas_rise) begin
         if (avg_last) begin
            acc_p   <= '0;
            acc_h   <= '0;
            avg_idx <= '0;
         end else begin
            acc_p   <= sum_p;
            acc_h   <= sum_h;
            avg_idx <= avg_idx + 2'd1;
         end
      end
   end
`else
   always_comb begin
      pub_fire   = meas_rise;
      pub_period = cnt;
      pub_high   = hcnt;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         period    <= '0;
         high_time <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         if (pub_fire) begin
            period    <= pub_period;
            high_time <= pub_high;
            out_valid <= 1'b1;
            timeout   <= 1'b0;
            if (out_valid && !out_ready)
               overrun <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (timeout_evt)
            timeout <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         state <= IDLE;
         cnt   <= '0;
         hcnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               state <= ARM;
               cnt   <= '0;
               hcnt  <= '0;
            end
            ARM: begin
               if (rise) begin
                  state <= MEASURE;
                  cnt   <= CNT_W'(1);
                  hcnt  <= CNT_W'(1);
               end else if (at_max) begin
                  cnt  <= '0;
                  hcnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            MEASURE: begin
               if (rise) begin
                  cnt  <= CNT_W'(1);
                  hcnt <= CNT_W'(1);
               end else if (at_max) begin
                  state <= ARM;
                  cnt   <= '0;
                  hcnt  <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (s)
                     hcnt <= hcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               hcnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter (default build, CNT_W=8): the driver pushes
// expected results, a negedge monitor pops and compares on every accepted handshake.
module tb_period_meter;

   localparam int unsigned CNT_W = 8;

   typedef struct {
      logic [CNT_W-1:0] p;
      logic [CNT_W-1:0] h;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sig_in;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
   logic             timeout;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   period_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sig_in    (sig_in),
      .period    (period),
      .high_time (high_time),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   // n full periods starting with a rising edge; on a fresh ARM the first edge has no result.
   task automatic wave(input int h, input int l, input int n, input bit fresh, input bit push);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         if (push && !(fresh && i == 0)) begin
            e.p = CNT_W'(h + l);
            e.h = CNT_W'(h);
            sb.push_back(e);
         end
         sig_in = 1'b1;
         tick(h);
         sig_in = 1'b0;
         tick(l);
      end
   endtask

   task automatic push_exp(input int p, input int h);
      exp_t e;
      e.p = CNT_W'(p);
      e.h = CNT_W'(h);
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got period %0d high %0d, expected no result", period, high_time);
         end else begin
            mon_e = sb.pop_front();
            check("sb_period", period, mon_e.p);
            check("sb_high", high_time, mon_e.h);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  lat;
      int  tcyc;
      bit  vseen;

      rst = 1'b1; en = 1'b0; sig_in = 1'b0; out_ready = 1'b1;
      tick(3);
      sig_in = 1'b1;
      tick(2);
      check("rst_period", period, 0);
      check("rst_high", high_time, 0);
      check("rst_valid", out_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout", timeout, 0);
      sig_in = 1'b0;
      rst = 1'b0;
      tick(3);

      // 5/5 wave: latency of the first result, then back-to-back results
      en = 1'b1;
      tick(3);
      wave(5, 5, 1, 1'b1, 1'b0);
      push_exp(10, 5);
      sig_in = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, 3);
      tick(2);
      sig_in = 1'b0;
      tick(5);
      wave(5, 5, 3, 1'b0, 1'b1);
      tick(6);
      en = 1'b0;
      tick(3);
      check("t1_overrun", overrun, 0);
      check("t1_drain", sb.size(), 0);

      // 3/7 wave with consumer stalled: overwrite and overrun
      out_ready = 1'b0;
      en = 1'b1;
      tick(3);
      wave(3, 7, 4, 1'b1, 1'b0);
      check("t2_valid", out_valid, 1);
      check("t2_overrun", overrun, 1);
      check("t2_period", period, 10);
      check("t2_high", high_time, 3);
      push_exp(10, 3);
      out_ready = 1'b1;
      tick(1);
      check("t2_valid_drop", out_valid, 0);
      en = 1'b0;
      tick(3);
      check("t2_drain", sb.size(), 0);

      // DC input: timeout only, then a 4/4 wave clears it
      en = 1'b1;
      tcyc = 0;
      vseen = 1'b0;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (out_valid) vseen = 1'b1;
         if (timeout) begin
            tcyc = i;
            break;
         end
      end
      #2;
      check("t3_timeout_window", (tcyc >= 255 && tcyc <= 260), 1);
      check("t3_no_valid", vseen, 0);
      check("t3_overrun_sticky", overrun, 1);
      wave(4, 4, 3, 1'b1, 1'b1);
      tick(4);
      check("t3_timeout_clear", timeout, 0);
      en = 1'b0;
      tick(3);
      check("t3_drain", sb.size(), 0);

      // en dropped mid-period: pending result kept, re-arm needs two fresh edges
      out_ready = 1'b0;
      en = 1'b1;
      tick(3);
      wave(5, 5, 2, 1'b1, 1'b0);
      en = 1'b0;
      tick(2);
      sig_in = 1'b1;
      tick(2);
      en = 1'b1;
      tick(3);
      sig_in = 1'b0;
      tick(6);
      sig_in = 1'b1;
      tick(6);
      check("t4_pending_valid", out_valid, 1);
      check("t4_pending_period", period, 10);
      check("t4_pending_high", high_time, 5);
      sig_in = 1'b0;
      tick(6);
      sig_in = 1'b1;
      tick(5);
      check("t4_new_period", period, 12);
      push_exp(12, 6);
      out_ready = 1'b1;
      tick(2);
      sig_in = 1'b0;
      tick(3);
      en = 1'b0;
      tick(3);
      check("t4_drain", sb.size(), 0);

      // reset mid-MEASURE with a pending result
      out_ready = 1'b0;
      en = 1'b1;
      tick(3);
      wave(5, 5, 2, 1'b1, 1'b0);
      check("t5_pre_valid", out_valid, 1);
      rst = 1'b1;
      tick(1);
      check("t5_period", period, 0);
      check("t5_high", high_time, 0);
      check("t5_valid", out_valid, 0);
      check("t5_overrun", overrun, 0);
      check("t5_timeout", timeout, 0);
      rst = 1'b0;
      en = 1'b0;
      out_ready = 1'b1;
      tick(3);
      check("final_drain", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
